exu_muldiv: RTL and testbench

- Multi-cycle RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the instruction, op1/op2 and rd address leaving ID/EX.
- Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.
- Raises a hold request to ctrl for the duration of the operation and issues a one-cycle register-file write when finished.

---
 rtl/exu_muldiv_if.sv | 49 ++++
 rtl/exu_muldiv.sv | 206 ++++++++++++++++++++
 tb/tb_exu_muldiv.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_muldiv_if.sv
// Port bundle between ID/EX, the multiply/divide unit, the register file and
// ctrl.
//   instr_i_idu2exu_exu     instruction leaving ID/EX (NOP when flushed)
//   op1_data_i_idu2exu_exu  rs1 value
//   op2_data_i_idu2exu_exu  rs2 value
//   rd_addr_i_idu2exu_exu   destination register
//   rd_data_o_exu_regs      result, zero outside the write cycle
//   rd_addr_o_exu_regs      destination of the result, zero outside the write cycle
//   rd_wen_o_exu_regs       one-cycle register-file write enable
//   hold_flag_o_exu_ctrl    stall request to ctrl
//   busy_o                  operation in flight (status)
// master: the surrounding pipeline; slave: the multiply/divide unit.
interface exu_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] instr_i_idu2exu_exu;
  logic [DATA_WIDTH-1:0] op1_data_i_idu2exu_exu;
  logic [DATA_WIDTH-1:0] op2_data_i_idu2exu_exu;
  logic [4:0]            rd_addr_i_idu2exu_exu;
  logic [DATA_WIDTH-1:0] rd_data_o_exu_regs;
  logic [4:0]            rd_addr_o_exu_regs;
  logic                  rd_wen_o_exu_regs;
  logic                  hold_flag_o_exu_ctrl;
  logic                  busy_o;

  modport master (
    output instr_i_idu2exu_exu,
    output op1_data_i_idu2exu_exu,
    output op2_data_i_idu2exu_exu,
    output rd_addr_i_idu2exu_exu,
    input  rd_data_o_exu_regs,
    input  rd_addr_o_exu_regs,
    input  rd_wen_o_exu_regs,
    input  hold_flag_o_exu_ctrl,
    input  busy_o
  );

  modport slave (
    input  instr_i_idu2exu_exu,
    input  op1_data_i_idu2exu_exu,
    input  op2_data_i_idu2exu_exu,
    input  rd_addr_i_idu2exu_exu,
    output rd_data_o_exu_regs,
    output rd_addr_o_exu_regs,
    output rd_wen_o_exu_regs,
    output hold_flag_o_exu_ctrl,
    output busy_o
  );
endinterface

// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit sitting behind the ID/EX register.
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, one bit per cycle, then applies the result sign.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  exu_muldiv_if.slave (ID/EX inputs, register-file write, hold, busy)
//
// state  | meaning
// S_IDLE | waiting for an M-extension instruction; accepts it this cycle
// S_CALC | one iteration per cycle, DATA_WIDTH cycles total
// S_DONE | result presented, one-cycle register-file write
module exu_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  exu_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]        cnt_q;
  logic [2:0]              f3_q;
  logic [4:0]              rd_addr_q;
  logic                    q_neg_q;
  logic                    r_neg_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [2*DATA_WIDTH-1:0] acc_q;

  logic [DATA_WIDTH-1:0] instr, op1, op2;
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic                  unused_instr_bits;

  assign instr  = bus.instr_i_idu2exu_exu;
  assign op1    = bus.op1_data_i_idu2exu_exu;
  assign op2    = bus.op2_data_i_idu2exu_exu;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register indices arrive pre-decoded; rs fields are not needed here.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  logic start;
  assign start = (state_q == S_IDLE) && (opcode == OPC_OP) && (funct7 == F7_MULDIV);

  // Operand decode for the accept cycle
  logic                  op1_signed, op2_signed, op1_neg, op2_neg;
  logic [DATA_WIDTH-1:0] op1_mag, op2_mag;
  logic                  is_div, div_by_zero, div_ovf, div_special;
  logic [DATA_WIDTH-1:0] special_quo, special_rem;

  assign op1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign op2_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign op1_neg    = op1_signed && op1[DATA_WIDTH-1];
  assign op2_neg    = op2_signed && op2[DATA_WIDTH-1];
  assign op1_mag    = op1_neg ? -op1 : op1;
  assign op2_mag    = op2_neg ? -op2 : op2;

  assign is_div      = funct3[2];
  assign div_by_zero = is_div && (op2 == '0);
  assign div_ovf     = is_div && !funct3[0] && (op1 == MIN_NEG) && (op2 == '1);
  assign div_special = div_by_zero || div_ovf;
  // Special results are parked in the accumulator as {remainder, quotient}
  // with both signs cleared, so DONE reads them like a normal division.
  assign special_quo = div_by_zero ? '1 : MIN_NEG;
  assign special_rem = div_by_zero ? op1 : '0;

  // One multiply step: add multiplicand to the high half if the low bit of
  // the multiplier is set, then shift the whole accumulator right.
  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                    (acc_q[0] ? {1'b0, b_q} : {(DATA_WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[DATA_WIDTH-1:1]};

  // One restoring-division step on {remainder, dividend/quotient}.
  logic [DATA_WIDTH:0]     div_trial;
  logic [2*DATA_WIDTH-1:0] div_next;
  assign div_trial = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, b_q};
  assign div_next  = div_trial[DATA_WIDTH] ?
                     {acc_q[2*DATA_WIDTH-2:0], 1'b0} :
                     {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};

  // FSM
  logic hold, busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold    = 1'b1;
          state_d = div_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        hold = 1'b1;
        busy = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_addr_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
    end else if (start) begin
      cnt_q     <= '0;
      f3_q      <= funct3;
      rd_addr_q <= bus.rd_addr_i_idu2exu_exu;
      if (div_special) begin
        acc_q   <= {special_rem, special_quo};
        b_q     <= '0;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end else if (is_div) begin
        acc_q   <= {{DATA_WIDTH{1'b0}}, op1_mag};
        b_q     <= op2_mag;
        q_neg_q <= op1_neg ^ op2_neg;
        r_neg_q <= op1_neg;
      end else begin
        acc_q   <= {{DATA_WIDTH{1'b0}}, op2_mag};
        b_q     <= op1_mag;
        q_neg_q <= op1_neg ^ op2_neg;
        r_neg_q <= 1'b0;
      end
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= f3_q[2] ? div_next : mul_next;
    end
  end

  // Result selection
  logic [2*DATA_WIDTH-1:0] prod_final;
  logic [DATA_WIDTH-1:0]   quo_final, rem_final, result;

  assign prod_final = q_neg_q ? -acc_q : acc_q;
  assign quo_final  = q_neg_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
  assign rem_final  = r_neg_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                                 acc_q[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    result = '0;
    case (f3_q)
      F3_MUL:                        result = prod_final[DATA_WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_final[2*DATA_WIDTH-1:DATA_WIDTH];
      F3_DIV, F3_DIVU:               result = quo_final;
      default:                       result = rem_final;
    endcase
  end

  logic in_done;
  assign in_done = (state_q == S_DONE);

  assign bus.rd_data_o_exu_regs   = in_done ? result : '0;
  assign bus.rd_addr_o_exu_regs   = in_done ? rd_addr_q : 5'd0;
  assign bus.rd_wen_o_exu_regs    = in_done && (rd_addr_q != 5'd0);
  assign bus.hold_flag_o_exu_ctrl = hold;
  assign bus.busy_o               = busy;

endmodule

// File: tb/tb_exu_muldiv.sv
module tb_exu_muldiv;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_muldiv_if #(.DATA_WIDTH(32)) u_if ();

  exu_muldiv #(.DATA_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // cycle stamps of every write pulse seen
  int cyc = 0;
  int wen_cycles[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (u_if.rd_wen_o_exu_regs === 1'b1) wen_cycles.push_back(cyc);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {hold, busy, wen, rd_addr, rd_data}
  function automatic logic [39:0] ctl_now();
    return {u_if.hold_flag_o_exu_ctrl, u_if.busy_o, u_if.rd_wen_o_exu_regs,
            u_if.rd_addr_o_exu_regs, u_if.rd_data_o_exu_regs};
  endfunction

  function automatic logic [31:0] mk_m(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference model: plain RV32M arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Presents one M instruction in an IDLE cycle and follows it to its DONE
  // cycle, checking control and data outputs every cycle. Returns at the
  // DONE cycle, so a following call issues back-to-back.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat);
    logic [39:0] exp_ctl;
    @(negedge clk);
    u_if.instr_i_idu2exu_exu    = mk_m(f3, rd);
    u_if.op1_data_i_idu2exu_exu = a;
    u_if.op2_data_i_idu2exu_exu = b;
    u_if.rd_addr_i_idu2exu_exu  = rd;
    #1;
    check($sformatf("%s accept", name), 64'(ctl_now()), 64'({1'b1, 1'b0, 1'b0, 5'd0, 32'd0}));
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      u_if.instr_i_idu2exu_exu    = INSTR_NOP;
      u_if.op1_data_i_idu2exu_exu = $urandom;
      u_if.op2_data_i_idu2exu_exu = $urandom;
      u_if.rd_addr_i_idu2exu_exu  = 5'($urandom);
      #1;
      if (c == lat) exp_ctl = {1'b0, 1'b1, rd != 5'd0, rd, exp_res};
      else          exp_ctl = {1'b1, 1'b1, 1'b0, 5'd0, 32'd0};
      check($sformatf("%s c%0d", name, c), 64'(ctl_now()), 64'(exp_ctl));
    end
  endtask

  task automatic idle_cycle(input string name, input logic [31:0] instr);
    @(negedge clk);
    u_if.instr_i_idu2exu_exu    = instr;
    u_if.op1_data_i_idu2exu_exu = 32'd5;
    u_if.op2_data_i_idu2exu_exu = 32'd0;
    u_if.rd_addr_i_idu2exu_exu  = 5'd7;
    #1;
    check(name, 64'(ctl_now()), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int nw;
    logic [2:0]  rf3;
    logic [4:0]  rrd;
    logic [31:0] ra, rb;
    logic [31:0] pick[5];

    vecs[0]  = '{"mul_7x6",      3'd0, 5'd5,  32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{"mulh_m1x2",    3'd1, 5'd6,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[2]  = '{"mulhu_m1x2",   3'd3, 5'd7,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  33};
    vecs[3]  = '{"mulhsu_m1x2",  3'd2, 5'd8,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{"div_m7_2",     3'd4, 5'd9,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[5]  = '{"rem_m7_2",     3'd6, 5'd10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[6]  = '{"divu_100_7",   3'd5, 5'd11, 32'd100,        32'd7,          32'd14,         33};
    vecs[7]  = '{"remu_100_7",   3'd7, 5'd12, 32'd100,        32'd7,          32'd2,          33};
    vecs[8]  = '{"divu_by0",     3'd5, 5'd13, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{"div_ovf",      3'd4, 5'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[10] = '{"rem_ovf",      3'd6, 5'd15, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[11] = '{"remu_by0",     3'd7, 5'd16, 32'h1234,       32'd0,          32'h1234,       1};
    vecs[12] = '{"mulh_min_min", 3'd1, 5'd17, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33};
    vecs[13] = '{"div_min_by0",  3'd4, 5'd18, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1};

    u_if.instr_i_idu2exu_exu    = INSTR_NOP;
    u_if.op1_data_i_idu2exu_exu = '0;
    u_if.op2_data_i_idu2exu_exu = '0;
    u_if.rd_addr_i_idu2exu_exu  = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", 64'(ctl_now()), 64'd0);
    rst = 1'b0;

    // directed vectors, issued back-to-back
    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].f3, vecs[i].rd, vecs[i].a, vecs[i].b,
                            vecs[i].res, vecs[i].lat);
    idle_cycle("idle after vectors", INSTR_NOP);

    // ADD and NOP are ignored
    idle_cycle("add ignored", 32'h0020_82B3);
    idle_cycle("after add", INSTR_NOP);
    idle_cycle("nop ignored", INSTR_NOP);

    // rd = x0: full latency, no write pulse
    nw = wen_cycles.size();
    do_op("mul_rd0", 3'd0, 5'd0, 32'd7, 32'd6, 32'd42, 33);
    idle_cycle("after rd0", INSTR_NOP);
    check("rd0 no write", 64'(wen_cycles.size()), 64'(nw));

    // two consecutive MULs: write pulses 34 cycles apart
    wen_cycles.delete();
    do_op("b2b_a", 3'd0, 5'd1, 32'd11, 32'd13, 32'd143, 33);
    do_op("b2b_b", 3'd0, 5'd2, 32'd12, 32'd12, 32'd144, 33);
    idle_cycle("after b2b", INSTR_NOP);
    check("b2b pulse count", 64'(wen_cycles.size()), 64'd2);
    if (wen_cycles.size() == 2)
      check("b2b spacing", 64'(wen_cycles[1] - wen_cycles[0]), 64'd34);

    // reset in the middle of a MUL
    nw = wen_cycles.size();
    @(negedge clk);
    u_if.instr_i_idu2exu_exu    = mk_m(3'd0, 5'd3);
    u_if.op1_data_i_idu2exu_exu = 32'd5;
    u_if.op2_data_i_idu2exu_exu = 32'd9;
    u_if.rd_addr_i_idu2exu_exu  = 5'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      u_if.instr_i_idu2exu_exu = INSTR_NOP;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-op reset idle", 64'(ctl_now()), 64'd0);
    repeat (40) @(negedge clk);
    check("mid-op reset no write", 64'(wen_cycles.size()), 64'(nw));
    do_op("mul_3x3_after_rst", 3'd0, 5'd4, 32'd3, 32'd3, 32'd9, 33);

    // reset wins over a start in the same cycle
    @(negedge clk);
    rst = 1'b1;
    u_if.instr_i_idu2exu_exu    = mk_m(3'd0, 5'd6);
    u_if.op1_data_i_idu2exu_exu = 32'd2;
    u_if.op2_data_i_idu2exu_exu = 32'd2;
    @(negedge clk);
    rst = 1'b0;
    u_if.instr_i_idu2exu_exu = INSTR_NOP;
    #1;
    check("reset beats start", 64'(ctl_now()), 64'd0);

    // randomized operations against the reference model
    for (int n = 0; n < 160; n++) begin
      for (int k = 0; k < 5; k++) begin
        case ($urandom_range(0, 7))
          0:       pick[k] = 32'd0;
          1:       pick[k] = 32'hFFFF_FFFF;
          2:       pick[k] = 32'h8000_0000;
          3:       pick[k] = $urandom_range(0, 20);
          default: pick[k] = $urandom;
        endcase
      end
      rf3 = 3'($urandom);
      rrd = 5'($urandom);
      ra  = pick[0];
      rb  = pick[1];
      do_op($sformatf("rnd%0d_f%0d", n, rf3), rf3, rrd, ra, rb, ref_res(rf3, ra, rb),
            ref_lat(rf3, ra, rb));
    end
    idle_cycle("final idle", INSTR_NOP);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
